fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the cpu decode/execute datapath. It owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake, with multiple requests in flight. Responses are buffered in a small prefetch FIFO and handed to decode over a valid/ready interface, each with its PC. A branch/jump redirect flushes the buffer and discards any in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, widths and the buffered-instruction type for the fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Pointer width of a DEPTH-entry buffer; counters are one bit wider.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush; head visible combinationally, push-to-head 1 cycle.
// No internal backpressure: the owner guarantees push only when a slot is free (push+pop when full is fine).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_dat,
  input  logic             pop,
  output fetch_entry_t     head_dat,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps up to DEPTH requests+buffered words in flight, redirect flushes; rvalid->instr_valid 1 cycle
// (0 cycles with FETCH_BYPASS_EN when the buffer is empty). Requests stall while buffer+in-flight reach DEPTH.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter int          ADDR_W   = 11,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc
);

  localparam int               CNT_W   = ptr_w(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   CREDITS = (CNT_W+1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] fifo_count;
  logic             accept;
  logic             rsp;
  logic             keep;
  logic             bypass;
  logic             push;
  logic             pop;
  fetch_entry_t     head_dat;
  fetch_entry_t     push_dat;

  assign imem_addr = fetch_pc[ADDR_W+1:2];
  assign imem_req  = !reset && !redirect_valid &&
                     (({1'b0, fifo_count} + {1'b0, outstanding}) < CREDITS);
  assign accept    = imem_req && imem_gnt;
  // A response with nothing outstanding can only belong to a request from before reset.
  assign rsp       = imem_rvalid && (outstanding != '0);
  assign keep      = rsp && !redirect_valid && (discard == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = keep && (fifo_count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid = !reset && ((fifo_count != '0) || bypass);
  assign pop         = !reset && !redirect_valid && instr_ready && (fifo_count != '0);
  assign push        = keep && !(bypass && instr_ready);
  assign push_dat    = '{pc: resp_pc, instr: imem_rdata};

  always_comb begin
    instr    = NOP_INSTR;
    instr_pc = '0;
    if (instr_valid) begin
      if (fifo_count != '0) begin
        instr    = head_dat.instr;
        instr_pc = head_dat.pc;
      end else begin
        instr    = imem_rdata;
        instr_pc = resp_pc;
      end
    end
  end

  always_comb begin
    case ({accept, rsp})
      2'b10:   outstanding_nxt = outstanding + CNT_ONE;
      2'b01:   outstanding_nxt = outstanding - CNT_ONE;
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc    <= redirect_pc & 32'hFFFF_FFFC;
      resp_pc     <= redirect_pc & 32'hFFFF_FFFC;
      outstanding <= outstanding_nxt;
      discard     <= outstanding_nxt;
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (keep)   resp_pc  <= resp_pc + 32'd4;
      if (rsp && !keep) discard <= discard - CNT_ONE;
      outstanding <= outstanding_nxt;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

endmodule
